// File: rtl/fetch_pkg.sv
// Shared types and default dimensions for the fetch sequencer and its return stack.
package fetch_pkg;

  localparam int DEF_ADDR_W      = 12;
  localparam int DEF_OPC_W       = 4;
  localparam int DEF_OPR_W       = 4;
  localparam int DEF_STACK_DEPTH = 4;

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_INC,
    ACT_LOAD,
    ACT_CALL,
    ACT_RET
  } pc_action_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address stack for CALL/RET. Pushing when full and popping when empty are ignored.
// The parent never requests a push and a pop in the same cycle.
module ret_stack #(
  parameter int ADDR_W      = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [SP_W-1:0]   sp;

  assign full  = (sp == SP_W'(STACK_DEPTH));
  assign empty = (sp == '0);
  assign top   = mem[IDX_W'(sp - SP_W'(1))];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  // NOTE: entries are never read at or above sp, so the storage needs no reset;
  // leaving it out lets synthesis map it to plain registers or RAM.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[IDX_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC, fetch/execute phase and instruction register with ROM wait states, execute stall
// and a hardware return stack for CALL/RET.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int OPC_W       = DEF_OPC_W,
  parameter int OPR_W       = DEF_OPR_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                   clk,
  input  logic                   Rst,
  input  logic [OPC_W+OPR_W-1:0] rom_data,
  input  logic                   rom_valid,
  input  logic                   incPC,
  input  logic                   loadPC,
  input  logic                   callPC,
  input  logic                   retPC,
  input  logic                   stall,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic                   phase,
  output logic [OPC_W-1:0]       instruction,
  output logic [OPR_W-1:0]       operand,
  output logic                   stack_overflow,
  output logic                   stack_underflow
);

  localparam int WORD_W = OPC_W + OPR_W;

  state_t            state, state_n;
  pc_action_t        action;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc, target, stack_top;
  logic [WORD_W-1:0] ir, ir_n;
  logic              ovf, unf, set_ovf, set_unf;
  logic              push, pop, stack_full, stack_empty;

  assign pc_inc = pc + ADDR_W'(1);
  // Jump address spans the IR operand field and the following ROM byte.
  assign target = ADDR_W'({ir[OPR_W-1:0], rom_data});

  always_comb begin
    if      (retPC)  action = ACT_RET;
    else if (callPC) action = ACT_CALL;
    else if (loadPC) action = ACT_LOAD;
    else if (incPC)  action = ACT_INC;
    else             action = ACT_NONE;
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case statements can leave a value held and infer a latch.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ir_n    = ir;
    push    = 1'b0;
    pop     = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    case (state)
      FETCH: begin
        if (rom_valid) begin
          ir_n    = rom_data;
          pc_n    = pc_inc;
          state_n = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          case (action)
            ACT_RET: begin
              if (!stack_empty) begin
                pc_n = stack_top;
                pop  = 1'b1;
              end else begin
                pc_n    = pc_inc;
                set_unf = 1'b1;
              end
              state_n = FETCH;
            end
            ACT_CALL: begin
              if (rom_valid) begin
                push    = !stack_full;
                set_ovf = stack_full;
                pc_n    = target;
                state_n = FETCH;
              end
            end
            ACT_LOAD: begin
              if (rom_valid) begin
                pc_n    = target;
                state_n = FETCH;
              end
            end
            ACT_INC: begin
              pc_n    = pc_inc;
              state_n = FETCH;
            end
            default: state_n = FETCH;
          endcase
        end
      end
      default: state_n = FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!Rst) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ir    <= ir_n;
      ovf   <= ovf | set_ovf;
      unf   <= unf | set_unf;
    end
  end

  ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (Rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stack_top),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  assign rom_addr        = pc;
  assign phase           = (state == EXEC);
  assign instruction     = ir[WORD_W-1:OPR_W];
  assign operand         = ir[OPR_W-1:0];
  assign stack_overflow  = ovf;
  assign stack_underflow = unf;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: each step drives one cycle of stimulus, queues the
// expected registered outputs, and compares them #1 after the clock edge.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic [7:0]  rom_data = '0;
  logic        rom_valid = 1'b0;
  logic        incPC = 1'b0, loadPC = 1'b0, callPC = 1'b0, retPC = 1'b0, stall = 1'b0;
  logic [11:0] rom_addr;
  logic        phase;
  logic [3:0]  instruction, operand;
  logic        stack_overflow, stack_underflow;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [11:0] pc;
    logic        ph;
    logic [7:0]  ir;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];

  fetch_sequencer dut (
    .clk             (clk),
    .Rst             (Rst),
    .rom_data        (rom_data),
    .rom_valid       (rom_valid),
    .incPC           (incPC),
    .loadPC          (loadPC),
    .callPC          (callPC),
    .retPC           (retPC),
    .stall           (stall),
    .rom_addr        (rom_addr),
    .phase           (phase),
    .instruction     (instruction),
    .operand         (operand),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // strb = {retPC, callPC, loadPC, incPC}
  task automatic drive(input logic rv, input logic [7:0] rd, input logic [3:0] strb,
                       input logic stl);
    rom_valid = rv;
    rom_data  = rd;
    {retPC, callPC, loadPC, incPC} = strb;
    stall     = stl;
  endtask

  task automatic tick(input string tag, input logic [11:0] epc, input logic eph,
                      input logic [7:0] eir, input logic eo, input logic eu);
    exp_t e;
    sb.push_back('{tag: tag, pc: epc, ph: eph, ir: eir, ovf: eo, unf: eu});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".pc"},  32'(rom_addr),                 32'(e.pc));
    chk({e.tag, ".ph"},  32'(phase),                    32'(e.ph));
    chk({e.tag, ".ir"},  32'({instruction, operand}),   32'(e.ir));
    chk({e.tag, ".ovf"}, 32'(stack_overflow),           32'(e.ovf));
    chk({e.tag, ".unf"}, 32'(stack_underflow),          32'(e.unf));
  endtask

  initial begin
    logic [11:0] ret_tgt [5];
    logic [11:0] pc_cur;
    ret_tgt = '{12'h302, 12'h202, 12'h102, 12'h002, 12'h004};

    // reset
    drive(1'b1, 8'hFF, 4'b0001, 1'b0);
    tick("rst0", 12'h000, 1'b0, 8'h00, 1'b0, 1'b0);
    tick("rst1", 12'h000, 1'b0, 8'h00, 1'b0, 1'b0);
    Rst = 1'b1;

    // sequential fetch with incPC
    drive(1'b1, 8'h11, 4'b0000, 1'b0); tick("f1",   12'h001, 1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 4'b0001, 1'b0); tick("e1",   12'h002, 1'b0, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 4'b0000, 1'b0); tick("f2",   12'h003, 1'b1, 8'h22, 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 4'b0001, 1'b0); tick("e2",   12'h004, 1'b0, 8'h22, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 4'b0000, 1'b0); tick("f3",   12'h005, 1'b1, 8'h33, 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 4'b0001, 1'b0); tick("e3",   12'h006, 1'b0, 8'h33, 1'b0, 1'b0);
    drive(1'b0, 8'h44, 4'b0000, 1'b0); tick("fwait", 12'h006, 1'b0, 8'h33, 1'b0, 1'b0);

    // loadPC held by ROM wait states
    drive(1'b1, 8'hA3, 4'b0000, 1'b0); tick("fA3",  12'h007, 1'b1, 8'hA3, 1'b0, 1'b0);
    drive(1'b0, 8'h45, 4'b0010, 1'b0); tick("ldw1", 12'h007, 1'b1, 8'hA3, 1'b0, 1'b0);
    drive(1'b0, 8'h45, 4'b0010, 1'b0); tick("ldw2", 12'h007, 1'b1, 8'hA3, 1'b0, 1'b0);
    drive(1'b1, 8'h45, 4'b0010, 1'b0); tick("ld",   12'h345, 1'b0, 8'hA3, 1'b0, 1'b0);

    // stall holds EXEC, then no strobe leaves PC unchanged
    drive(1'b1, 8'h00, 4'b0000, 1'b0); tick("f346", 12'h346, 1'b1, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 4'b0001, 1'b1); tick("stl",  12'h346, 1'b1, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 4'b0000, 1'b0); tick("none", 12'h346, 1'b0, 8'h00, 1'b0, 1'b0);

    // CALL at 0x010 to 0x200 and RET to 0x012
    drive(1'b1, 8'h10, 4'b0000, 1'b0); tick("f347", 12'h347, 1'b1, 8'h10, 1'b0, 1'b0);
    drive(1'b1, 8'h10, 4'b0010, 1'b0); tick("ld10", 12'h010, 1'b0, 8'h10, 1'b0, 1'b0);
    drive(1'b1, 8'h52, 4'b0000, 1'b0); tick("fcal", 12'h011, 1'b1, 8'h52, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 4'b0100, 1'b0); tick("calw", 12'h011, 1'b1, 8'h52, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 4'b0100, 1'b0); tick("call", 12'h200, 1'b0, 8'h52, 1'b0, 1'b0);
    drive(1'b1, 8'h60, 4'b0000, 1'b0); tick("fret", 12'h201, 1'b1, 8'h60, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 4'b1000, 1'b0); tick("ret",  12'h012, 1'b0, 8'h60, 1'b0, 1'b0);

    // PC wrap from 0xFFF
    drive(1'b1, 8'h4F, 4'b0000, 1'b0); tick("f012", 12'h013, 1'b1, 8'h4F, 1'b0, 1'b0);
    drive(1'b1, 8'hFE, 4'b0010, 1'b0); tick("ldFFE", 12'hFFE, 1'b0, 8'h4F, 1'b0, 1'b0);
    drive(1'b1, 8'h01, 4'b0000, 1'b0); tick("fFFE", 12'hFFF, 1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 4'b0001, 1'b0); tick("wrap", 12'h000, 1'b0, 8'h01, 1'b0, 1'b0);

    // all strobes with sp=1: RET wins and empties the stack
    drive(1'b1, 8'h5A, 4'b0000, 1'b0); tick("f000", 12'h001, 1'b1, 8'h5A, 1'b0, 1'b0);
    drive(1'b1, 8'hBC, 4'b0100, 1'b0); tick("cABC", 12'hABC, 1'b0, 8'h5A, 1'b0, 1'b0);
    drive(1'b1, 8'h77, 4'b0000, 1'b0); tick("fABC", 12'hABD, 1'b1, 8'h77, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 4'b1111, 1'b0); tick("prio", 12'h002, 1'b0, 8'h77, 1'b0, 1'b0);
    drive(1'b1, 8'h88, 4'b0000, 1'b0); tick("f002", 12'h003, 1'b1, 8'h88, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 4'b1000, 1'b0); tick("sp0",  12'h004, 1'b0, 8'h88, 1'b0, 1'b1);

    // reset clears sticky flags
    Rst = 1'b0;
    drive(1'b1, 8'h00, 4'b0000, 1'b0); tick("rst2", 12'h000, 1'b0, 8'h00, 1'b0, 1'b0);
    Rst = 1'b1;

    // five nested CALLs into a four-deep stack
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 8'(8'h50 + k), 4'b0000, 1'b0);
      tick($sformatf("nf%0d", k), 12'((k - 1) * 12'h100 + 1), 1'b1, 8'(8'h50 + k), 1'b0, 1'b0);
      drive(1'b1, 8'h00, 4'b0100, 1'b0);
      tick($sformatf("nc%0d", k), 12'(k * 12'h100), 1'b0, 8'(8'h50 + k), k == 5, 1'b0);
    end

    // five RETs: four pops then underflow
    pc_cur = 12'h500;
    for (int j = 0; j < 5; j++) begin
      drive(1'b1, 8'h60, 4'b0000, 1'b0);
      tick($sformatf("rf%0d", j), pc_cur + 12'h001, 1'b1, 8'h60, 1'b1, 1'b0);
      drive(1'b1, 8'h00, 4'b1000, 1'b0);
      tick($sformatf("rr%0d", j), ret_tgt[j], 1'b0, 8'h60, 1'b1, j == 4);
      pc_cur = ret_tgt[j];
    end
    drive(1'b0, 8'h00, 4'b0000, 1'b0); tick("sticky", 12'h004, 1'b0, 8'h60, 1'b1, 1'b1);

    // reset during FETCH wait
    Rst = 1'b0;
    drive(1'b0, 8'h00, 4'b0000, 1'b0); tick("rstw", 12'h000, 1'b0, 8'h00, 1'b0, 1'b0);
    Rst = 1'b1;

    // reset during stall with a non-empty stack
    drive(1'b1, 8'h51, 4'b0000, 1'b0); tick("sf1",  12'h001, 1'b1, 8'h51, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 4'b0100, 1'b0); tick("sc1",  12'h100, 1'b0, 8'h51, 1'b0, 1'b0);
    drive(1'b1, 8'h99, 4'b0000, 1'b0); tick("sf2",  12'h101, 1'b1, 8'h99, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 4'b1000, 1'b1); tick("sstl", 12'h101, 1'b1, 8'h99, 1'b0, 1'b0);
    Rst = 1'b0;
    drive(1'b1, 8'h00, 4'b1000, 1'b1); tick("rsts", 12'h000, 1'b0, 8'h00, 1'b0, 1'b0);
    Rst = 1'b1;
    drive(1'b1, 8'h60, 4'b0000, 1'b0); tick("pf",   12'h001, 1'b1, 8'h60, 1'b0, 1'b0);
    drive(1'b1, 8'h00, 4'b1000, 1'b0); tick("psp0", 12'h002, 1'b0, 8'h60, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
